// File: rtl/ofs_plat_utils_avalon_mm_rr_arbiter_pkg.sv
// rtl/ofs_plat_utils_avalon_mm_rr_arbiter_pkg.sv - shared types and helpers for the Avalon-MM round-robin arbiter
//
// Purpose: holds the arbiter state encoding and the source-id width helper
// used by the arbiter top and its tag FIFO.

package ofs_plat_utils_avalon_mm_rr_arbiter_pkg;

    // IDLE: free round-robin arbitration. WBURST: grant locked to the source
    // that owns an in-flight write burst.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WBURST = 1'b1
    } arb_state_e;

    // Bits needed to name one of num_src sources (at least one bit).
    function automatic int src_id_width(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/ofs_plat_utils_avalon_mm_rr_tag_fifo.sv
// rtl/ofs_plat_utils_avalon_mm_rr_tag_fifo.sv - read tag FIFO tracking outstanding read commands
//
// Purpose: stores one {source id, burstcount} tag per outstanding read so
// returning read beats can be steered back to their requester.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   push_i         write push_data_i at the tail
//   push_data_i    tag to store
//   pop_i          drop the head entry
//   head_o         head entry (combinational from storage)
//   full_o         DEPTH entries held
//   empty_o        no entries held

module ofs_plat_utils_avalon_mm_rr_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full_o  = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(DEPTH));
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the head slot, so a push is still taken
    // when full; the write lands in the slot being vacated.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/ofs_plat_utils_avalon_mm_rr_arbiter.sv
// rtl/ofs_plat_utils_avalon_mm_rr_arbiter.sv - round-robin Avalon-MM arbiter, NUM_SRC requesters onto one m0 port
//
// Purpose: arbitrates Avalon-MM commands from NUM_SRC sources onto m0 with
// zero-cycle command latency, locks the grant for write bursts, and routes
// read responses back through a tag FIFO.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   s_*                            per-source slave ports, source i in slice i
//   m0_*                           shared master port toward the downstream

module ofs_plat_utils_avalon_mm_rr_arbiter
    import ofs_plat_utils_avalon_mm_rr_arbiter_pkg::*;
#(
    parameter int NUM_SRC          = 2,
    parameter int DATA_WIDTH       = 32,
    parameter int SYMBOL_WIDTH     = 8,
    parameter int HDL_ADDR_WIDTH   = 10,
    parameter int BURSTCOUNT_WIDTH = 4,
    parameter int RESPONSE_WIDTH   = 2,
    parameter int RSP_FIFO_DEPTH   = 8
) (
    input  logic                                             clk,
    input  logic                                             reset,

    output logic [NUM_SRC-1:0]                               s_waitrequest,
    output logic [NUM_SRC*DATA_WIDTH-1:0]                    s_readdata,
    output logic [NUM_SRC-1:0]                               s_readdatavalid,
    output logic [NUM_SRC*RESPONSE_WIDTH-1:0]                s_response,
    input  logic [NUM_SRC*HDL_ADDR_WIDTH-1:0]                s_address,
    input  logic [NUM_SRC*BURSTCOUNT_WIDTH-1:0]              s_burstcount,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]                    s_writedata,
    input  logic [NUM_SRC*(DATA_WIDTH/SYMBOL_WIDTH)-1:0]     s_byteenable,
    input  logic [NUM_SRC-1:0]                               s_read,
    input  logic [NUM_SRC-1:0]                               s_write,

    input  logic                                             m0_waitrequest,
    input  logic [DATA_WIDTH-1:0]                            m0_readdata,
    input  logic                                             m0_readdatavalid,
    input  logic [RESPONSE_WIDTH-1:0]                        m0_response,
    output logic [HDL_ADDR_WIDTH-1:0]                        m0_address,
    output logic [BURSTCOUNT_WIDTH-1:0]                      m0_burstcount,
    output logic [DATA_WIDTH-1:0]                            m0_writedata,
    output logic [(DATA_WIDTH/SYMBOL_WIDTH)-1:0]             m0_byteenable,
    output logic                                             m0_read,
    output logic                                             m0_write
);

    localparam int ID_W  = src_id_width(NUM_SRC);
    localparam int BE_W  = DATA_WIDTH / SYMBOL_WIDTH;
    localparam int BC_W  = BURSTCOUNT_WIDTH;
    localparam int TAG_W = ID_W + BC_W;

    // Per-source command fields unpacked for muxing by grant index.
    logic [HDL_ADDR_WIDTH-1:0] addr_a  [NUM_SRC];
    logic [BC_W-1:0]           bc_a    [NUM_SRC];
    logic [DATA_WIDTH-1:0]     wdata_a [NUM_SRC];
    logic [BE_W-1:0]           be_a    [NUM_SRC];

    arb_state_e        state_q;
    logic [ID_W-1:0]   last_grant_q;
    logic [BC_W-1:0]   beats_left_q;
    logic [BC_W-1:0]   beat_cnt_q;

    logic [ID_W-1:0]   grant;
    logic              grant_valid;
    logic [ID_W-1:0]   rr_cand;
    logic              cmd_en;
    logic              accept;
    logic [BC_W-1:0]   bc_eff;

    logic              tag_full;
    logic              tag_empty;
    logic [TAG_W-1:0]  tag_head;
    logic [ID_W-1:0]   head_id;
    logic [BC_W-1:0]   head_bc;
    logic              rsp_fire;
    logic              rsp_last;
    logic              rd_block;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign addr_a[i]  = s_address[i*HDL_ADDR_WIDTH +: HDL_ADDR_WIDTH];
        assign bc_a[i]    = s_burstcount[i*BC_W +: BC_W];
        assign wdata_a[i] = s_writedata[i*DATA_WIDTH +: DATA_WIDTH];
        assign be_a[i]    = s_byteenable[i*BE_W +: BE_W];
    end

    // ------------------------------------------------------------------
    // Response side: the FIFO head names the source owning returning beats.
    // ------------------------------------------------------------------
    assign head_id  = tag_head[TAG_W-1 -: ID_W];
    assign head_bc  = tag_head[BC_W-1:0];
    assign rsp_fire = m0_readdatavalid & ~tag_empty & ~reset;
    assign rsp_last = rsp_fire & (beat_cnt_q == head_bc - BC_W'(1));

    // A full FIFO still admits a read when its head retires this cycle.
    assign rd_block = tag_full & ~rsp_last;

    // ------------------------------------------------------------------
    // Grant selection: locked owner during a write burst, otherwise the
    // first eligible source after the last accepted one.
    // ------------------------------------------------------------------
    always_comb begin
        grant       = last_grant_q;
        grant_valid = 1'b0;
        rr_cand     = last_grant_q;
        if (state_q == WBURST) begin
            grant_valid = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_SRC; k++) begin
                rr_cand = ID_W'((int'(last_grant_q) + k) % NUM_SRC);
                if (!grant_valid &&
                    ((s_read[rr_cand] && !rd_block) || s_write[rr_cand])) begin
                    grant       = rr_cand;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    assign cmd_en = grant_valid & ~reset;

    assign m0_read       = cmd_en & (state_q == IDLE) & s_read[grant] & ~rd_block;
    assign m0_write      = cmd_en & s_write[grant];
    assign m0_address    = addr_a[grant];
    assign m0_burstcount = bc_a[grant];
    assign m0_writedata  = wdata_a[grant];
    assign m0_byteenable = be_a[grant];

    assign accept = (m0_read | m0_write) & ~m0_waitrequest;
    assign bc_eff = (m0_burstcount == '0) ? BC_W'(1) : m0_burstcount;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign s_waitrequest[i]   = ~(cmd_en && (grant == ID_W'(i)) && !m0_waitrequest &&
                                      !(s_read[i] && rd_block));
        assign s_readdatavalid[i] = rsp_fire && (head_id == ID_W'(i));
    end

    // Data and response fan out to every source; only the valid bit selects.
    assign s_readdata = {NUM_SRC{m0_readdata}};
    assign s_response = {NUM_SRC{m0_response}};

    // ------------------------------------------------------------------
    // Arbitration state, burst lock and response beat counting.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_SRC - 1);
            beats_left_q <= '0;
            beat_cnt_q   <= '0;
        end else begin
            if (accept) begin
                last_grant_q <= grant;
                case (state_q)
                    IDLE: begin
                        if (m0_write && (bc_eff > BC_W'(1))) begin
                            state_q      <= WBURST;
                            beats_left_q <= bc_eff - BC_W'(1);
                        end
                    end
                    WBURST: begin
                        if (beats_left_q == BC_W'(1)) begin
                            state_q      <= IDLE;
                            beats_left_q <= '0;
                        end else begin
                            beats_left_q <= beats_left_q - BC_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
            if (rsp_fire) begin
                beat_cnt_q <= rsp_last ? '0 : beat_cnt_q + BC_W'(1);
            end
        end
    end

    ofs_plat_utils_avalon_mm_rr_tag_fifo #(
        .DEPTH (RSP_FIFO_DEPTH),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (accept & m0_read),
        .push_data_i ({grant, bc_eff}),
        .pop_i       (rsp_last),
        .head_o      (tag_head),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    // ------------------------------------------------------------------
    // Protocol checks.
    // ------------------------------------------------------------------
    a_no_orphan_rdv : assert property (@(posedge clk) disable iff (reset)
        !(m0_readdatavalid && tag_empty))
        else $error("m0_readdatavalid with no outstanding read");

    a_rd_wr_excl : assert property (@(posedge clk) disable iff (reset)
        (s_read & s_write) == '0)
        else $error("s_read and s_write asserted together");

endmodule

// File: tb/tb_ofs_plat_utils_avalon_mm_rr_arbiter.sv
// tb/tb_ofs_plat_utils_avalon_mm_rr_arbiter.sv - self-checking bench for the Avalon-MM round-robin arbiter

module tb_ofs_plat_utils_avalon_mm_rr_arbiter;

    localparam int NS    = 2;
    localparam int DW    = 32;
    localparam int HAW   = 10;
    localparam int BCW   = 4;
    localparam int RW    = 2;
    localparam int BEW   = 4;
    localparam int DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NS-1:0]        s_waitrequest;
    logic [NS*DW-1:0]     s_readdata;
    logic [NS-1:0]        s_readdatavalid;
    logic [NS*RW-1:0]     s_response;
    logic [NS*HAW-1:0]    s_address;
    logic [NS*BCW-1:0]    s_burstcount;
    logic [NS*DW-1:0]     s_writedata;
    logic [NS*BEW-1:0]    s_byteenable;
    logic [NS-1:0]        s_read;
    logic [NS-1:0]        s_write;
    logic                 m0_waitrequest;
    logic [DW-1:0]        m0_readdata;
    logic                 m0_readdatavalid;
    logic [RW-1:0]        m0_response;
    logic [HAW-1:0]       m0_address;
    logic [BCW-1:0]       m0_burstcount;
    logic [DW-1:0]        m0_writedata;
    logic [BEW-1:0]       m0_byteenable;
    logic                 m0_read;
    logic                 m0_write;

    ofs_plat_utils_avalon_mm_rr_arbiter #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .SYMBOL_WIDTH(8), .HDL_ADDR_WIDTH(HAW),
        .BURSTCOUNT_WIDTH(BCW), .RESPONSE_WIDTH(RW), .RSP_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .s_response(s_response),
        .s_address(s_address), .s_burstcount(s_burstcount),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_read(s_read), .s_write(s_write),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid), .m0_response(m0_response),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; logic [HAW-1:0] addr; int bc; } cmd_t;
    typedef struct { int src; bit wr; logic [HAW-1:0] addr; logic [DW-1:0] data; } acc_t;
    typedef struct { int src; bit last; } pend_t;
    typedef struct { int exp_src; logic [NS-1:0] rdv; logic [DW-1:0] exp_data; logic [DW-1:0] got_data;
                     logic [RW-1:0] exp_resp; logic [RW-1:0] got_resp; } rsp_t;

    cmd_t  src_q [NS][$];
    int    beat_idx [NS];
    acc_t  acc_log [$];
    pend_t ret_q [$];
    rsp_t  rsp_log [$];

    int total = 0;
    int bad   = 0;
    int seq   = 0;

    bit stall_force = 0;
    int stall_pct   = 0;
    bit ret_en      = 1;
    int ret_pct     = 100;

    // Snapshot of what was driven this cycle, and what was observed.
    logic [NS-1:0]  snap_read, snap_write;
    logic [HAW-1:0] snap_addr [NS];
    int             snap_bc_eff [NS];
    bit             snap_wait, snap_ret_valid, snap_ret_last;
    int             snap_outstanding;
    logic [NS-1:0]  obs_wait;
    logic           obs_read, obs_write;
    logic [HAW-1:0] obs_addr;

    function automatic logic [HAW-1:0] mk_addr(int src, int s);
        return {2'(src), 8'(s)};
    endfunction

    function automatic logic [DW-1:0] wdata(logic [HAW-1:0] a, int b);
        return {a, 6'd0, 16'(b)};
    endfunction

    function automatic int eff(int bc);
        return (bc == 0) ? 1 : bc;
    endfunction

    task automatic push_cmd(int src, bit wr, int bc);
        cmd_t c;
        c.wr = wr; c.addr = mk_addr(src, seq); c.bc = bc;
        seq++;
        src_q[src].push_back(c);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            beat_idx[i] = 0;
        end
        ret_q.delete();
        s_read = '0; s_write = '0; s_address = '0; s_burstcount = '0;
        s_writedata = '0; s_byteenable = '0;
        m0_waitrequest = 1'b0; m0_readdatavalid = 1'b0; m0_readdata = '0; m0_response = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: drive sources/downstream after the edge, sample on the falling edge.
    task automatic cycle();
        cmd_t  c;
        pend_t p;
        acc_t  a;
        rsp_t  r;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                c = src_q[i][0];
                s_read[i]  = !c.wr;
                s_write[i] = c.wr;
                s_address[i*HAW +: HAW]    = c.addr;
                s_burstcount[i*BCW +: BCW] = 4'(c.bc);
                s_writedata[i*DW +: DW]    = wdata(c.addr, beat_idx[i]);
                s_byteenable[i*BEW +: BEW] = c.addr[3:0];
                snap_addr[i]   = c.addr;
                snap_bc_eff[i] = eff(c.bc);
            end else begin
                s_read[i]  = 1'b0;
                s_write[i] = 1'b0;
                snap_addr[i]   = '0;
                snap_bc_eff[i] = 1;
            end
        end
        m0_waitrequest = stall_force || ($urandom_range(99) < stall_pct);
        snap_outstanding = 0;
        foreach (ret_q[k]) if (ret_q[k].last) snap_outstanding++;
        snap_ret_valid = 0;
        snap_ret_last  = 0;
        if (ret_en && ret_q.size() > 0 && ($urandom_range(99) < ret_pct)) begin
            m0_readdatavalid = 1'b1;
            m0_readdata      = $urandom;
            m0_response      = 2'($urandom);
            snap_ret_valid   = 1;
            snap_ret_last    = ret_q[0].last;
        end else begin
            m0_readdatavalid = 1'b0;
        end
        snap_read  = s_read;
        snap_write = s_write;
        snap_wait  = m0_waitrequest;

        @(negedge clk);
        obs_wait  = s_waitrequest;
        obs_read  = m0_read;
        obs_write = m0_write;
        obs_addr  = m0_address;
        if (snap_ret_valid) begin
            p = ret_q.pop_front();
            r.exp_src  = p.src;
            r.rdv      = s_readdatavalid;
            r.exp_data = m0_readdata;
            r.got_data = s_readdata[p.src*DW +: DW];
            r.exp_resp = m0_response;
            r.got_resp = s_response[p.src*RW +: RW];
            rsp_log.push_back(r);
        end
        if ((m0_read || m0_write) && !m0_waitrequest) begin
            a.src  = int'(m0_address[9:8]);
            a.wr   = m0_write;
            a.addr = m0_address;
            a.data = m0_writedata;
            acc_log.push_back(a);
            if (m0_read) begin
                for (int k = 0; k < eff(int'(m0_burstcount)); k++) begin
                    p.src  = a.src;
                    p.last = (k == eff(int'(m0_burstcount)) - 1);
                    ret_q.push_back(p);
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            if ((s_read[i] || s_write[i]) && !s_waitrequest[i] && src_q[i].size() > 0) begin
                if (s_write[i]) begin
                    beat_idx[i]++;
                    if (beat_idx[i] >= eff(src_q[i][0].bc)) begin
                        void'(src_q[i].pop_front());
                        beat_idx[i] = 0;
                    end
                end else begin
                    void'(src_q[i].pop_front());
                end
            end
        end
    endtask

    task automatic run_until_idle(input int max_cycles, output bit timed_out);
        int n = 0;
        timed_out = 0;
        ret_en = 1;
        while ((src_q[0].size() > 0 || src_q[1].size() > 0 || ret_q.size() > 0) && n < max_cycles) begin
            cycle();
            n++;
        end
        if (n >= max_cycles) timed_out = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_all();
        s_read = 2'b11;
        m0_readdatavalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (s_waitrequest !== 2'b11) begin bad++; $display("FAIL reset_waitreq got=%b exp=11", s_waitrequest); end
        total++; if (s_readdatavalid !== 2'b00) begin bad++; $display("FAIL reset_rdv got=%b exp=00", s_readdatavalid); end
        total++; if (m0_read !== 1'b0) begin bad++; $display("FAIL reset_m0_read got=%b exp=0", m0_read); end
        total++; if (m0_write !== 1'b0) begin bad++; $display("FAIL reset_m0_write got=%b exp=0", m0_write); end
        clear_all();
        #1;
        reset = 1'b0;
        #1;
        total++; if (s_waitrequest !== 2'b11 || m0_read !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%b/%b exp=11/0", s_waitrequest, m0_read); end
    endtask

    task automatic test_alternating_reads();
        bit to;
        acc_log.delete(); rsp_log.delete();
        stall_pct = 0; ret_pct = 50;
        for (int k = 0; k < 4; k++) begin
            push_cmd(0, 0, 1);
            push_cmd(1, 0, 1);
        end
        run_until_idle(200, to);
        total++; if (to) begin bad++; $display("FAIL alt_timeout got=timeout exp=drained"); end
        total++; if (acc_log.size() != 8) begin bad++; $display("FAIL alt_count got=%0d exp=8", acc_log.size()); end
        for (int k = 0; k < acc_log.size(); k++) begin
            total++;
            if (acc_log[k].src != (k % 2) || acc_log[k].wr) begin
                bad++; $display("FAIL alt_grant[%0d] got=src%0d wr=%0d exp=src%0d rd", k, acc_log[k].src, acc_log[k].wr, k % 2);
            end
        end
        total++; if (rsp_log.size() != 8) begin bad++; $display("FAIL alt_rsp_count got=%0d exp=8", rsp_log.size()); end
        for (int k = 0; k < rsp_log.size(); k++) begin
            total++;
            if (rsp_log[k].rdv !== NS'(1 << rsp_log[k].exp_src) || rsp_log[k].got_data !== rsp_log[k].exp_data) begin
                bad++; $display("FAIL alt_rsp[%0d] got=rdv%b/%h exp=src%0d/%h", k, rsp_log[k].rdv, rsp_log[k].got_data, rsp_log[k].exp_src, rsp_log[k].exp_data);
            end
        end
        // Sources alternate, so responses come back 0,1,0,1 as well.
        for (int k = 0; k < rsp_log.size(); k++) begin
            total++;
            if (rsp_log[k].exp_src != (k % 2)) begin bad++; $display("FAIL alt_rsp_order[%0d] got=%0d exp=%0d", k, rsp_log[k].exp_src, k % 2); end
        end
    endtask

    task automatic test_write_burst_lock();
        bit to;
        logic [HAW-1:0] wa;
        acc_log.delete();
        stall_pct = 0; ret_pct = 100;
        wa = mk_addr(1, seq);
        push_cmd(1, 1, 4);
        cycle();
        push_cmd(0, 0, 1);
        run_until_idle(100, to);
        total++; if (to || acc_log.size() != 5) begin bad++; $display("FAIL wlock_count got=%0d exp=5", acc_log.size()); end
        for (int k = 0; k < 4 && k < acc_log.size(); k++) begin
            total++;
            if (acc_log[k].src != 1 || !acc_log[k].wr || acc_log[k].data !== wdata(wa, k)) begin
                bad++; $display("FAIL wlock_beat[%0d] got=src%0d wr=%0d d=%h exp=src1 wr=1 d=%h", k, acc_log[k].src, acc_log[k].wr, acc_log[k].data, wdata(wa, k));
            end
        end
        if (acc_log.size() == 5) begin
            total++; if (acc_log[4].src != 0 || acc_log[4].wr) begin bad++; $display("FAIL wlock_after got=src%0d wr=%0d exp=src0 rd", acc_log[4].src, acc_log[4].wr); end
        end
    endtask

    task automatic test_stall_mid_burst();
        bit to;
        logic [HAW-1:0] wa;
        acc_log.delete();
        stall_pct = 0; ret_pct = 100;
        wa = mk_addr(1, seq);
        push_cmd(1, 1, 4);
        cycle();
        push_cmd(0, 0, 1);
        cycle();
        stall_force = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            total++;
            if (obs_write !== 1'b1 || obs_read !== 1'b0 || obs_addr !== wa || obs_wait !== 2'b11) begin
                bad++; $display("FAIL stall_hold[%0d] got=wr%b rd%b a=%h wait=%b exp=wr1 rd0 a=%h wait=11", k, obs_write, obs_read, obs_addr, obs_wait, wa);
            end
        end
        stall_force = 0;
        run_until_idle(100, to);
        total++; if (to || acc_log.size() != 5) begin bad++; $display("FAIL stall_count got=%0d exp=5", acc_log.size()); end
        for (int k = 0; k < 4 && k < acc_log.size(); k++) begin
            total++;
            if (acc_log[k].src != 1 || acc_log[k].data !== wdata(wa, k)) begin
                bad++; $display("FAIL stall_beat[%0d] got=src%0d d=%h exp=src1 d=%h", k, acc_log[k].src, acc_log[k].data, wdata(wa, k));
            end
        end
    endtask

    task automatic test_fifo_full();
        bit to;
        acc_log.delete(); rsp_log.delete();
        stall_pct = 0; ret_en = 0;
        for (int k = 0; k < 9; k++) push_cmd(0, 0, 1);
        repeat (12) cycle();
        total++; if (acc_log.size() != DEPTH) begin bad++; $display("FAIL full_accepted got=%0d exp=%0d", acc_log.size(), DEPTH); end
        total++; if (obs_wait[0] !== 1'b1 || obs_read !== 1'b0) begin bad++; $display("FAIL full_stall got=wait%b rd%b exp=wait1 rd0", obs_wait[0], obs_read); end
        ret_en = 1; ret_pct = 100;
        cycle();
        ret_en = 0;
        total++; if (acc_log.size() != DEPTH + 1) begin bad++; $display("FAIL full_same_cycle got=%0d exp=%0d", acc_log.size(), DEPTH + 1); end
        run_until_idle(100, to);
        total++; if (to || rsp_log.size() != 9) begin bad++; $display("FAIL full_drain got=%0d exp=9", rsp_log.size()); end
    endtask

    task automatic test_burst_read();
        bit to;
        logic [NS-1:0] exp_rdv;
        acc_log.delete(); rsp_log.delete();
        stall_pct = 0; ret_pct = 100;
        push_cmd(0, 0, 3);
        cycle();
        push_cmd(1, 0, 1);
        run_until_idle(100, to);
        total++; if (to || rsp_log.size() != 4) begin bad++; $display("FAIL bread_count got=%0d exp=4", rsp_log.size()); end
        for (int k = 0; k < rsp_log.size(); k++) begin
            exp_rdv = (k < 3) ? 2'b01 : 2'b10;
            total++;
            if (rsp_log[k].rdv !== exp_rdv || rsp_log[k].got_data !== rsp_log[k].exp_data) begin
                bad++; $display("FAIL bread_beat[%0d] got=rdv%b d=%h exp=rdv%b d=%h", k, rsp_log[k].rdv, rsp_log[k].got_data, exp_rdv, rsp_log[k].exp_data);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit to;
        stall_pct = 0; ret_pct = 100;
        push_cmd(1, 1, 4);
        cycle();
        cycle();
        reset = 1'b1;
        #1;
        total++; if (s_waitrequest !== 2'b11) begin bad++; $display("FAIL rmid_waitreq got=%b exp=11", s_waitrequest); end
        total++; if (m0_write !== 1'b0 || m0_read !== 1'b0) begin bad++; $display("FAIL rmid_cmd got=wr%b rd%b exp=wr0 rd0", m0_write, m0_read); end
        clear_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        acc_log.delete();
        push_cmd(0, 0, 1);
        push_cmd(1, 0, 1);
        run_until_idle(100, to);
        total++;
        if (to || acc_log.size() != 2 || acc_log[0].src != 0 || acc_log[1].src != 1) begin
            bad++; $display("FAIL rmid_restart got=n%0d first=src%0d exp=n2 first=src0", acc_log.size(), (acc_log.size() > 0) ? acc_log[0].src : -1);
        end
    endtask

    // Reference: spec rules applied to the snapshot of each cycle's inputs.
    task automatic test_random();
        int  m_last, m_lock, m_left, g, nrsp;
        bit  blocked, exp_rd, exp_wr, to;
        logic [NS-1:0] exp_wait;
        do_reset();
        acc_log.delete(); rsp_log.delete();
        m_last = NS - 1; m_lock = -1; m_left = 0;
        stall_pct = 25; ret_en = 1; ret_pct = 40;
        repeat (600) begin
            for (int i = 0; i < NS; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(2) == 0) begin
                    if ($urandom_range(1) == 1) push_cmd(i, 1, $urandom_range(4));
                    else push_cmd(i, 0, $urandom_range(3));
                end
            end
            nrsp = rsp_log.size();
            cycle();
            blocked = (snap_outstanding == DEPTH) && !(snap_ret_valid && snap_ret_last);
            g = -1;
            if (m_lock >= 0) g = m_lock;
            else begin
                for (int k = 1; k <= NS; k++) begin
                    int j = (m_last + k) % NS;
                    if (g < 0 && ((snap_read[j] && !blocked) || snap_write[j])) g = j;
                end
            end
            exp_rd = (g >= 0) && snap_read[g] && !blocked;
            exp_wr = (g >= 0) && snap_write[g];
            exp_wait = '1;
            if (g >= 0 && !snap_wait && !(snap_read[g] && blocked)) exp_wait[g] = 1'b0;
            total++;
            if (obs_read !== exp_rd || obs_write !== exp_wr || obs_wait !== exp_wait) begin
                bad++; $display("FAIL rand_cmd got=rd%b wr%b wait=%b exp=rd%b wr%b wait=%b", obs_read, obs_write, obs_wait, exp_rd, exp_wr, exp_wait);
            end
            if (exp_rd || exp_wr) begin
                total++;
                if (obs_addr !== snap_addr[g]) begin bad++; $display("FAIL rand_addr got=%h exp=%h", obs_addr, snap_addr[g]); end
                if (!snap_wait) begin
                    m_last = g;
                    if (exp_wr) begin
                        if (m_lock < 0) begin
                            if (snap_bc_eff[g] > 1) begin m_lock = g; m_left = snap_bc_eff[g] - 1; end
                        end else begin
                            m_left--;
                            if (m_left == 0) m_lock = -1;
                        end
                    end
                end
            end
            if (rsp_log.size() > nrsp) begin
                total++;
                if (rsp_log[nrsp].rdv !== NS'(1 << rsp_log[nrsp].exp_src) ||
                    rsp_log[nrsp].got_data !== rsp_log[nrsp].exp_data ||
                    rsp_log[nrsp].got_resp !== rsp_log[nrsp].exp_resp) begin
                    bad++; $display("FAIL rand_rsp got=rdv%b d=%h r=%b exp=src%0d d=%h r=%b", rsp_log[nrsp].rdv, rsp_log[nrsp].got_data, rsp_log[nrsp].got_resp, rsp_log[nrsp].exp_src, rsp_log[nrsp].exp_data, rsp_log[nrsp].exp_resp);
                end
            end
        end
        stall_pct = 0;
        run_until_idle(500, to);
        total++; if (to) begin bad++; $display("FAIL rand_drain got=timeout exp=drained"); end
    endtask

    initial begin
        test_reset();
        test_alternating_reads();
        test_write_burst_lock();
        test_stall_mid_burst();
        test_fifo_full();
        test_burst_read();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ofs_plat_utils_avalon_mm_rr_arbiter.md
OFS_PLAT_UTILS_AVALON_MM_RR_ARBITER -- requirements
Module: ofs_plat_utils_avalon_mm_rr_arbiter

Interface
REQ-001 SHALL use clock clk; reset reset, asynchronous, active-high.
REQ-002 SHALL have parameters (name, default, meaning):
- NUM_SRC, 2, number of Avalon-MM requesters, 2..8.
- DATA_WIDTH, 32, data bits.
- SYMBOL_WIDTH, 8, bits per byteenable lane.
- HDL_ADDR_WIDTH, 10, address bits.
- BURSTCOUNT_WIDTH, 4, burstcount bits.
- RESPONSE_WIDTH, 2, response bits.
- RSP_FIFO_DEPTH, 8, outstanding read commands tracked, power of 2.
REQ-003 SHALL have ports (name, direction, width, meaning). Per-source signals are packed vectors with source i in slice i.
- clk  in  1  clock.
- reset  in  1  async reset.
- s_waitrequest  out  NUM_SRC  per-source stall.
- s_readdata  out  NUM_SRC*DATA_WIDTH  per-source read data.
- s_readdatavalid  out  NUM_SRC  per-source read beat valid.
- s_response  out  NUM_SRC*RESPONSE_WIDTH  per-source response.
- s_address  in  NUM_SRC*HDL_ADDR_WIDTH  address.
- s_burstcount  in  NUM_SRC*BURSTCOUNT_WIDTH  burst length.
- s_writedata  in  NUM_SRC*DATA_WIDTH  write data.
- s_byteenable  in  NUM_SRC*(DATA_WIDTH/SYMBOL_WIDTH)  byte enables.
- s_read  in  NUM_SRC  read request.
- s_write  in  NUM_SRC  write request.
- m0_waitrequest  in  1  downstream stall.
- m0_readdata  in  DATA_WIDTH  read data.
- m0_readdatavalid  in  1  read beat valid.
- m0_response  in  RESPONSE_WIDTH  response.
- m0_address, m0_burstcount, m0_writedata, m0_byteenable, m0_read, m0_write  out  as s_ slice  shared command.

Function
REQ-004 SHALL drive m0 command signals combinationally from the granted source, or drive m0_read=m0_write=0 when no source is granted (zero-cycle command latency).
REQ-005 SHALL use the states IDLE (no lock) and WBURST (locked to the write-burst owner).
REQ-006 In IDLE, SHALL grant by round-robin among sources with s_read|s_write, starting at last_grant+1 modulo NUM_SRC.
REQ-007 SHALL update last_grant only when a command beat is accepted (granted source active and m0_waitrequest=0).
REQ-008 On acceptance of the first write beat with burstcount>1, SHALL enter WBURST, load beats_left=burstcount-1, and hold the grant.
REQ-009 In WBURST, SHALL decrement beats_left on each accepted beat and return to IDLE when the beat with beats_left=1 is accepted.
REQ-010 SHALL treat burstcount=0 as 1.
REQ-011 SHALL complete a read in one accepted beat; the grant is released the following cycle.
REQ-012 SHALL set s_waitrequest[i]=0 only when i is granted, m0_waitrequest=0, and not (s_read[i] and tag FIFO full); all other sources see 1.
REQ-013 SHALL block reads when the tag FIFO is full: m0_read=0 and round-robin skips sources presenting reads.
REQ-014 On each accepted read, SHALL push {source id, burstcount} into the tag FIFO.
REQ-015 SHALL route m0_readdatavalid, m0_readdata and m0_response combinationally to the FIFO-head source; all other sources see readdatavalid=0.
REQ-016 SHALL count received beats against the head burstcount and pop the head on its last beat.
REQ-017 On a simultaneous push and pop with the FIFO full, SHALL accept the push (the pop frees the entry in the same cycle).
REQ-018 SHALL ignore m0_readdatavalid when the FIFO is empty; this is an assertion error in simulation.
REQ-019 SHALL require s_read and s_write of one source to be mutually exclusive; this is an assertion error in simulation.

Reset
REQ-020 During reset, SHALL clear the state to IDLE, last_grant to NUM_SRC-1, beats_left, FIFO pointers and the beat counter to 0.
REQ-021 During reset, SHALL hold all s_waitrequest=1, s_readdatavalid=0, m0_read=0 and m0_write=0.
REQ-022 SHALL discard outstanding tags on reset asserted mid-operation; the downstream is reset together with this block.

Structure
REQ-023 The shared utils package SHALL hold the state enum and the helper function that computes the source-id width, clog2(NUM_SRC).
REQ-024 The tag FIFO SHALL be a sub-module ofs_plat_utils_avalon_mm_rr_tag_fifo (registered storage, full/empty flags, combinational head).

Verification
REQ-025 Sources 0 and 1 both issue single reads each cycle with m0_waitrequest=0 -> grants alternate 0,1,0,1; each source receives its own data in order.
REQ-026 Source 1 issues a 4-beat write while source 0 requests a read -> four consecutive m0_write beats from source 1, then source 0's read.
REQ-027 m0_waitrequest=1 for 3 cycles mid-burst -> beats_left holds, the grant does not change, and no beat is duplicated.
REQ-028 RSP_FIFO_DEPTH=8 reads are outstanding with no returns -> the 9th read stalls until the first returned beat, then is accepted in that same cycle.
REQ-029 A burst read of burstcount=3 from source 0, then a single read from source 1 -> 3 beats on s_readdatavalid[0], then 1 beat on s_readdatavalid[1].
REQ-030 Reset asserted during a write burst -> outputs go to reset values immediately; after release, arbitration starts at source 0.
